// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-and-add multiplier: state encoding,
// legal operand widths and the default width.
package mul_pkg;

    localparam int MUL_WIDTH_DEF = 16;
    localparam int MUL_WIDTH_MIN = 4;
    localparam int MUL_WIDTH_MAX = 32;

    typedef logic [2:0] mul_state_t;

    localparam mul_state_t ST_IDLE    = 3'd0;
    localparam mul_state_t ST_LOAD    = 3'd1;
    localparam mul_state_t ST_CHECK   = 3'd2;
    localparam mul_state_t ST_ITER    = 3'd3;
    localparam mul_state_t ST_FIXSIGN = 3'd4;
    localparam mul_state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/mul_datapath.sv
// Operand/magnitude registers, min/swap comparator, shift-and-add accumulator
// and final negation. Signed handling only when MUL_SIGNED_EN is defined.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_conv,
    input  logic               i_setup,
    input  logic               i_step,
    input  logic               i_negate,
    input  logic [WIDTH-1:0]   i_op_a,
    input  logic [WIDTH-1:0]   i_op_b,
    input  logic               i_signed,
    output logic               o_zero,
    output logic               o_last,
    output logic               o_neg,
    output logic [2*WIDTH-1:0] o_acc_nxt
);

    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_mplier;
    logic [PW-1:0]    r_mcand;
    logic [PW-1:0]    r_acc;
    logic             r_neg;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg;
    logic [PW-1:0]    w_acc_nxt;

`ifdef MUL_SIGNED_EN
    logic r_sgn;

    // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    assign w_mag_a = f_mag(r_op_a, r_sgn);
    assign w_mag_b = f_mag(r_op_b, r_sgn);
    assign w_neg   = r_sgn & (r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sgn <= 1'b0;
        end else if (i_load) begin
            r_sgn <= i_signed;
        end
    end
`else
    logic [1:0] w_unused_cfg;

    assign w_unused_cfg = {i_signed, i_negate};
    assign w_mag_a      = r_op_a;
    assign w_mag_b      = r_op_b;
    assign w_neg        = 1'b0;
`endif

    always_comb begin
        w_acc_nxt = r_acc;
        if (i_step && r_mplier[0]) begin
            w_acc_nxt = r_acc + r_mcand;
        end
`ifdef MUL_SIGNED_EN
        if (i_negate) begin
            w_acc_nxt = -r_acc;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_neg    <= 1'b0;
            r_mplier <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
        end else begin
            if (i_load) begin
                r_op_a <= i_op_a;
                r_op_b <= i_op_b;
            end
            if (i_conv) begin
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_neg   <= w_neg;
            end
            // Smaller magnitude drives the iteration count; ties pick mag_b.
            if (i_setup) begin
                r_acc <= '0;
                if (r_mag_a < r_mag_b) begin
                    r_mplier <= r_mag_a;
                    r_mcand  <= {{WIDTH{1'b0}}, r_mag_b};
                end else begin
                    r_mplier <= r_mag_b;
                    r_mcand  <= {{WIDTH{1'b0}}, r_mag_a};
                end
            end else if (i_step) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
`ifdef MUL_SIGNED_EN
            else if (i_negate) begin
                r_acc <= w_acc_nxt;
            end
`endif
        end
    end

    assign o_zero    = (r_mag_a == '0) || (r_mag_b == '0);
    assign o_last    = (r_mplier[WIDTH-1:1] == '0);
    assign o_neg     = r_neg;
    assign o_acc_nxt = w_acc_nxt;

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative multiplier sequencer: start/done handshake, FSM and output registers.
// Optional signed mode is enabled by defining MUL_SIGNED_EN.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               signed_op,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               zero_skip
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < MUL_WIDTH_MIN || WIDTH > MUL_WIDTH_MAX) begin : g_width_bad
        $error("mul_seq_unit: WIDTH out of range");
    end

    mul_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic               r_zero_skip;

    logic               w_load;
    logic               w_conv;
    logic               w_setup;
    logic               w_step;
    logic               w_negate;
    logic               w_zero;
    logic               w_last;
    logic               w_neg;
    logic               w_iter_end;
    logic [2*WIDTH-1:0] w_acc_nxt;

    assign w_load  = (r_state == ST_IDLE) && start;
    assign w_conv  = (r_state == ST_LOAD);
    assign w_setup = (r_state == ST_CHECK) && !w_zero;
    assign w_step  = (r_state == ST_ITER);
`ifdef MUL_SIGNED_EN
    assign w_negate = (r_state == ST_FIXSIGN);
`else
    logic w_unused_neg;

    assign w_negate     = 1'b0;
    assign w_unused_neg = w_neg;
`endif

    // The step counter is a hard bound; the multiplier running dry ends ITER first.
    assign w_iter_end = w_last || (r_cnt == CNT_W'(WIDTH - 1));

    mul_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_load    (w_load),
        .i_conv    (w_conv),
        .i_setup   (w_setup),
        .i_step    (w_step),
        .i_negate  (w_negate),
        .i_op_a    (op_a),
        .i_op_b    (op_b),
        .i_signed  (signed_op),
        .o_zero    (w_zero),
        .o_last    (w_last),
        .o_neg     (w_neg),
        .o_acc_nxt (w_acc_nxt)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_product   <= '0;
            r_zero_skip <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_zero) begin
                        r_product   <= '0;
                        r_zero_skip <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_iter_end) begin
`ifdef MUL_SIGNED_EN
                        if (w_neg) begin
                            r_state <= ST_FIXSIGN;
                        end else
`endif
                        begin
                            r_product   <= w_acc_nxt;
                            r_zero_skip <= 1'b0;
                            r_state     <= ST_DONE;
                        end
                    end
                end
`ifdef MUL_SIGNED_EN
                ST_FIXSIGN: begin
                    r_product   <= w_acc_nxt;
                    r_zero_skip <= 1'b0;
                    r_state     <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state == ST_LOAD) || (r_state == ST_CHECK) ||
                       (r_state == ST_ITER) || (r_state == ST_FIXSIGN);
    assign done      = (r_state == ST_DONE);
    assign product   = r_product;
    assign zero_skip = r_zero_skip;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Self-checking bench for mul_seq_unit (WIDTH=8): directed cases, reset abort,
// ignored start pulses and randomized operands against a reference model.
module tb_mul_seq_unit;

    localparam int W = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           signed_op = 1'b0;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic           busy;
    logic           done;
    logic           zero_skip;
    logic [2*W-1:0] product;

    int             n_checks = 0;
    int             n_pass = 0;
    logic [2*W-1:0] last_prod = '0;

    always #5 clock = ~clock;

    mul_seq_unit #(
        .WIDTH(W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .signed_op (signed_op),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .zero_skip (zero_skip)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer multiply; latency from the bit length of the
    // smaller magnitude plus handshake and optional sign-fix cycles.
    function automatic void ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [2*W-1:0] p, output int lat, output logic zs);
        logic         sgn_mode;
        logic         sa;
        logic         sb;
        int           va;
        int           vb;
        int           ma;
        int           mb;
        int           m;
        int           n;
        sgn_mode = s;
`ifndef MUL_SIGNED_EN
        sgn_mode = 1'b0;
`endif
        sa = sgn_mode && a[W-1];
        sb = sgn_mode && b[W-1];
        va = sa ? int'(a) - (1 << W) : int'(a);
        vb = sb ? int'(b) - (1 << W) : int'(b);
        ma = (va < 0) ? -va : va;
        mb = (vb < 0) ? -vb : vb;
        p  = (2*W)'(va * vb);
        zs = (ma == 0) || (mb == 0);
        if (zs) begin
            lat = 2;
            p   = '0;
        end else begin
            m = (ma < mb) ? ma : mb;
            n = 0;
            while (m != 0) begin
                n++;
                m = m / 2;
            end
            lat = n + 2 + ((sa ^ sb) ? 1 : 0);
        end
    endfunction

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [2*W-1:0] exp_p, input int exp_lat,
                          input logic exp_zs, input bit poke);
        int cyc;
        bit seen;
        @(negedge clock);
        op_a      = a;
        op_b      = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = poke;
        chk({tag, "/busy_rise"}, 64'(busy), 64'd1);
        chk({tag, "/prod_hold"}, 64'(product), 64'(last_prod));
        if (poke) begin
            op_a      = W'($urandom);
            op_b      = W'($urandom);
            signed_op = ~s;
        end
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 64) begin
            @(posedge clock);
            #1;
            cyc++;
            if (done) seen = 1;
        end
        chk({tag, "/done_seen"}, 64'(seen), 64'd1);
        chk({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "/product"}, 64'(product), 64'(exp_p));
        chk({tag, "/zero_skip"}, 64'(zero_skip), 64'(exp_zs));
        chk({tag, "/busy_fall"}, 64'(busy), 64'd0);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk({tag, "/done_pulse"}, 64'(done), 64'd0);
        chk({tag, "/prod_after"}, 64'(product), 64'(exp_p));
        if (poke) begin
            @(posedge clock);
            #1;
            chk({tag, "/no_restart"}, 64'({busy, done}), 64'd0);
        end
        last_prod = exp_p;
    endtask

    task automatic run_rand(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s);
        logic [2*W-1:0] p;
        int             lat;
        logic           zs;
        ref_mul(a, b, s, p, lat, zs);
        run_op(tag, a, b, s, p, lat, zs, 1'b0);
    endtask

    initial begin
        int done_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (2) @(posedge clock);
        #1;
        chk("rst/busy", 64'(busy), 64'd0);
        chk("rst/done", 64'(done), 64'd0);
        chk("rst/product", 64'(product), 64'd0);
        chk("rst/zero_skip", 64'(zero_skip), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'd143, 6, 1'b0, 1'b0);
        run_op("u0x200", 8'd0, 8'd200, 1'b0, 16'd0, 2, 1'b1, 1'b0);
        run_op("u3x255", 8'd3, 8'd255, 1'b0, 16'd765, 4, 1'b0, 1'b0);
        run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'd65025, 10, 1'b0, 1'b0);
`ifdef MUL_SIGNED_EN
        run_op("s-5x7", 8'hFB, 8'd7, 1'b1, 16'hFFDD, 6, 1'b0, 1'b0);
        run_op("s-128x-128", 8'h80, 8'h80, 1'b1, 16'd16384, 10, 1'b0, 1'b0);
`else
        run_op("s_ign251x7", 8'hFB, 8'd7, 1'b1, 16'd1757, 5, 1'b0, 1'b0);
        run_op("s_ign128x128", 8'h80, 8'h80, 1'b1, 16'd16384, 10, 1'b0, 1'b0);
`endif
        run_op("poke13x11", 8'd13, 8'd11, 1'b0, 16'd143, 6, 1'b0, 1'b1);

        // Abort a long multiply in ITER with an asynchronous reset.
        @(negedge clock);
        op_a  = 8'd255;
        op_b  = 8'd255;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("abort/pre_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort/busy", 64'(busy), 64'd0);
        chk("abort/done", 64'(done), 64'd0);
        chk("abort/product", 64'(product), 64'd0);
        chk("abort/zero_skip", 64'(zero_skip), 64'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        last_prod = '0;
        done_cnt  = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (done) done_cnt++;
        end
        chk("abort/no_done", 64'(done_cnt), 64'd0);
        run_op("post6x7", 8'd6, 8'd7, 1'b0, 16'd42, 5, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom);
            if ($urandom_range(0, 5) == 0) ra = 8'h80;
            run_rand($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
